// File: rtl/clod_pim_pkg.sv
// Shared constants and writer state encoding for the PIM LUT row programming path.
// Imported by the row writer, its interface and the row assembly buffer.
package clod_pim_pkg;

    localparam int CLOD_ELEMENT_WIDTH    = 8;
    localparam int CLOD_NUM_ROW_ELEMENTS = 256;
    localparam int CLOD_ROW_ADDR_WIDTH   = 16;
    localparam int CLOD_IDX_WIDTH        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } writer_state_e;

    // A row is malformed whenever "reached the final slot" and in_last disagree.
    function automatic logic row_len_error(input logic at_final_idx, input logic last_flag);
        return at_final_idx ^ last_flag;
    endfunction

endpackage

// File: rtl/clod_pim_lut_row_writer_if.sv
// Command, entry stream and row write port of the LUT row writer, bundled as one interface.
// The writer uses the slave view; whoever feeds it and owns the subarray uses master.
interface clod_pim_lut_row_writer_if
    import clod_pim_pkg::*;
#(
    parameter int num_row_elements = CLOD_NUM_ROW_ELEMENTS,
    parameter int element_width    = CLOD_ELEMENT_WIDTH,
    parameter int row_addr_width   = CLOD_ROW_ADDR_WIDTH
);

    logic                                      cmd_valid;
    logic                                      cmd_ready;
    logic [row_addr_width-1:0]                 cmd_row_addr;

    logic                                      in_valid;
    logic                                      in_ready;
    logic [element_width-1:0]                  in_data;
    logic                                      in_last;

    logic                                      row_wr_valid;
    logic                                      row_wr_ready;
    logic [row_addr_width-1:0]                 row_wr_addr;
    logic [num_row_elements*element_width-1:0] row_wr_data;

    modport master (
        output cmd_valid, cmd_row_addr,
        output in_valid, in_data, in_last,
        output row_wr_ready,
        input  cmd_ready, in_ready,
        input  row_wr_valid, row_wr_addr, row_wr_data
    );

    modport slave (
        input  cmd_valid, cmd_row_addr,
        input  in_valid, in_data, in_last,
        input  row_wr_ready,
        output cmd_ready, in_ready,
        output row_wr_valid, row_wr_addr, row_wr_data
    );

endinterface

// File: rtl/clod_pim_row_assembly_buffer.sv
// Row image storage: one indexed entry write per cycle, a synchronous clear-all,
// and the whole row presented flat with entry i at bits [i*element_width +: element_width].
module clod_pim_row_assembly_buffer
    import clod_pim_pkg::*;
#(
    parameter int num_row_elements = CLOD_NUM_ROW_ELEMENTS,
    parameter int element_width    = CLOD_ELEMENT_WIDTH,
    parameter int idx_width        = $clog2(num_row_elements)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clear,
    input  logic                                      wr_en,
    input  logic [idx_width-1:0]                      wr_idx,
    input  logic [element_width-1:0]                  wr_data,
    output logic [num_row_elements*element_width-1:0] row_data
);

    logic [num_row_elements*element_width-1:0] row_q;

    // Clear wins over a write so a new command always starts from an all-zero image.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
        end else if (clear) begin
            row_q <= '0;
        end else if (wr_en) begin
            row_q[int'(wr_idx)*element_width +: element_width] <= wr_data;
        end
    end

    assign row_data = row_q;

endmodule

// File: rtl/clod_pim_lut_row_writer.sv
// Programs one PIM LUT row: accepts a row command, collects the entry byte stream into
// a row image, then issues a single wide write to the subarray write port.
module clod_pim_lut_row_writer
    import clod_pim_pkg::*;
#(
    parameter int num_row_elements = CLOD_NUM_ROW_ELEMENTS,
    parameter int element_width    = CLOD_ELEMENT_WIDTH,
    parameter int row_addr_width   = CLOD_ROW_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    clod_pim_lut_row_writer_if.slave bus,
    output logic                     busy,
    output logic                     err_len
);

    localparam int idx_width = $clog2(num_row_elements);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_FILL   = FILL;
    localparam logic [1:0] ST_COMMIT = COMMIT;

    localparam logic [idx_width-1:0] FINAL_IDX = idx_width'(num_row_elements - 1);

    logic [1:0]                                state;
    logic [1:0]                                next_state;
    logic [idx_width-1:0]                      idx;
    logic [row_addr_width-1:0]                 row_addr_q;
    logic                                      cmd_ready_q;
    logic                                      in_ready_q;
    logic                                      row_wr_valid_q;
    logic                                      cmd_fire;
    logic                                      in_fire;
    logic                                      wr_fire;
    logic                                      at_final_idx;
    logic                                      row_done;
    logic [num_row_elements*element_width-1:0] row_image;

    assign cmd_fire     = bus.cmd_valid && cmd_ready_q;
    assign in_fire      = bus.in_valid && in_ready_q;
    assign wr_fire      = row_wr_valid_q && bus.row_wr_ready;
    assign at_final_idx = (idx == FINAL_IDX);
    assign row_done     = in_fire && (at_final_idx || bus.in_last);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (cmd_fire) next_state = ST_FILL;
            ST_FILL:   if (row_done) next_state = ST_COMMIT;
            ST_COMMIT: if (wr_fire)  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Ready/valid/busy are registered decodes of the next state, so no input reaches them
    // combinationally and they all read low while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            row_addr_q     <= '0;
            cmd_ready_q    <= 1'b0;
            in_ready_q     <= 1'b0;
            row_wr_valid_q <= 1'b0;
            busy           <= 1'b0;
            err_len        <= 1'b0;
        end else begin
            state          <= next_state;
            cmd_ready_q    <= (next_state == ST_IDLE);
            in_ready_q     <= (next_state == ST_FILL);
            row_wr_valid_q <= (next_state == ST_COMMIT);
            busy           <= (next_state != ST_IDLE);
            err_len        <= in_fire && row_len_error(at_final_idx, bus.in_last);
            if (cmd_fire) begin
                row_addr_q <= bus.cmd_row_addr;
                idx        <= '0;
            end else if (in_fire && !at_final_idx) begin
                idx <= idx + 1'b1;
            end
        end
    end

    clod_pim_row_assembly_buffer #(
        .num_row_elements (num_row_elements),
        .element_width    (element_width),
        .idx_width        (idx_width)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .clear    (cmd_fire),
        .wr_en    (in_fire),
        .wr_idx   (idx),
        .wr_data  (bus.in_data),
        .row_data (row_image)
    );

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.in_ready     = in_ready_q;
    assign bus.row_wr_valid = row_wr_valid_q;
    assign bus.row_wr_addr  = row_addr_q;
    assign bus.row_wr_data  = row_image;

endmodule

// File: tb/tb_clod_pim_lut_row_writer.sv
// Scenario bench for the LUT row writer: expected row images are queued when a row is
// driven and popped when the writer presents its row write.
module tb_clod_pim_lut_row_writer;
    import clod_pim_pkg::*;

    localparam int NUM = 256;
    localparam int EW  = 8;
    localparam int AW  = 16;

    typedef struct {
        logic [AW-1:0]     addr;
        logic [NUM*EW-1:0] data;
        bit                err;
    } row_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err_len;

    int vectors      = 0;
    int miscompares  = 0;
    int err_cycles   = 0;
    int valid_cycles = 0;
    int wr_count     = 0;

    row_exp_t sb_q[$];

    clod_pim_lut_row_writer_if bus ();

    clod_pim_lut_row_writer dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_len === 1'b1) err_cycles++;
        if (bus.row_wr_valid === 1'b1) valid_cycles++;
    end

    always @(posedge clk) begin
        if (!rst && bus.row_wr_valid === 1'b1 && bus.row_wr_ready === 1'b1) wr_count++;
    end

    function automatic logic [7:0] entry_val(input int pattern, input int k);
        logic [7:0] kb;
        kb = k[7:0];
        if (pattern == 0) return kb ^ 8'hA5;
        return 8'((k + 1) * 17);
    endfunction

    // Drives one command and n entries from a negedge; optionally queues the expected row.
    task automatic drive_row(input logic [AW-1:0] addr, input int n, input bit set_last,
                             input int pattern, input int gap_pct, input bit push,
                             output bit ok, output bit ready_after_cmd);
        row_exp_t e;
        int       guard;
        ok              = 1'b1;
        ready_after_cmd = 1'b0;
        e.addr = addr;
        e.data = '0;
        e.err  = !(set_last && n == NUM);
        for (int k = 0; k < n; k++) e.data[k*EW +: EW] = entry_val(pattern, k);
        if (push) sb_q.push_back(e);

        bus.cmd_valid    = 1'b1;
        bus.cmd_row_addr = addr;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (bus.cmd_ready !== 1'b1) ok = 1'b0;
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
        ready_after_cmd = (bus.in_ready === 1'b1);

        for (int k = 0; k < n; k++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = entry_val(pattern, k);
            bus.in_last  = set_last && (k == n - 1);
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (bus.in_ready !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic row_handshake();
        bus.row_wr_ready = 1'b1;
        @(negedge clk);
        bus.row_wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b0 || bus.in_ready !== 1'b0 || bus.row_wr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_handshakes got cmd_ready=%b in_ready=%b wr_valid=%b exp 0 0 0",
                     bus.cmd_ready, bus.in_ready, bus.row_wr_valid);
        end
        vectors++;
        if (busy !== 1'b0 || err_len !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status got busy=%b err_len=%b exp 0 0", busy, err_len);
        end
        vectors++;
        if (bus.row_wr_addr !== '0 || bus.row_wr_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_row got addr=%h data_nonzero=%b exp addr 0000 data zero",
                     bus.row_wr_addr, bus.row_wr_data != '0);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release_cmd_ready got %b exp 1", bus.cmd_ready);
        end
    endtask

    task automatic test_full_row();
        row_exp_t exp;
        bit ok, rac;
        int e0, bad;
        e0 = err_cycles;
        drive_row(16'h0012, NUM, 1'b1, 0, 0, 1'b1, ok, rac);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL full_handshake_timeout got timeout exp accepted");
        end
        vectors++;
        if (rac !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_first_entry_latency got in_ready=%b exp 1", rac);
        end
        vectors++;
        if (bus.row_wr_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_wr_valid_latency got valid=%b busy=%b exp 1 1", bus.row_wr_valid, busy);
        end
        exp = sb_q.pop_front();
        vectors++;
        if (bus.row_wr_addr !== exp.addr) begin
            miscompares++;
            $display("[TB] FAIL full_addr got %h exp %h", bus.row_wr_addr, exp.addr);
        end
        bad = -1;
        for (int i = NUM - 1; i >= 0; i--)
            if (bus.row_wr_data[i*EW +: EW] !== exp.data[i*EW +: EW]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL full_data entry %0d got %h exp %h", bad,
                     bus.row_wr_data[bad*EW +: EW], exp.data[bad*EW +: EW]);
        end
        row_handshake();
        vectors++;
        if (bus.row_wr_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_return_idle got valid=%b cmd_ready=%b busy=%b exp 0 1 0",
                     bus.row_wr_valid, bus.cmd_ready, busy);
        end
        vectors++;
        if (err_cycles - e0 != 0) begin
            miscompares++;
            $display("[TB] FAIL full_err_len got %0d high cycles exp 0", err_cycles - e0);
        end
    endtask

    task automatic test_short_row();
        row_exp_t exp;
        bit ok, rac;
        int e0, bad;
        drive_row(16'h0012, NUM, 1'b1, 0, 0, 1'b1, ok, rac);
        exp = sb_q.pop_front();
        vectors++;
        if (!ok || bus.row_wr_valid !== 1'b1 || bus.row_wr_data !== exp.data) begin
            miscompares++;
            $display("[TB] FAIL short_prefill_row got ok=%b valid=%b data_match=%b exp 1 1 1",
                     ok, bus.row_wr_valid, bus.row_wr_data === exp.data);
        end
        row_handshake();
        e0 = err_cycles;
        drive_row(16'h0034, 4, 1'b1, 1, 0, 1'b1, ok, rac);
        vectors++;
        if (!ok || bus.row_wr_valid !== 1'b1 || err_len !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL short_commit got ok=%b valid=%b err_len=%b exp 1 1 1",
                     ok, bus.row_wr_valid, err_len);
        end
        exp = sb_q.pop_front();
        vectors++;
        if (bus.row_wr_addr !== exp.addr) begin
            miscompares++;
            $display("[TB] FAIL short_addr got %h exp %h", bus.row_wr_addr, exp.addr);
        end
        bad = -1;
        for (int i = NUM - 1; i >= 0; i--)
            if (bus.row_wr_data[i*EW +: EW] !== exp.data[i*EW +: EW]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL short_data entry %0d got %h exp %h", bad,
                     bus.row_wr_data[bad*EW +: EW], exp.data[bad*EW +: EW]);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (err_cycles - e0 != 1) begin
            miscompares++;
            $display("[TB] FAIL short_err_pulse got %0d high cycles exp 1", err_cycles - e0);
        end
        row_handshake();
    endtask

    task automatic test_backpressure();
        row_exp_t exp;
        bit ok, rac;
        int w0;
        drive_row(16'h0012, NUM, 1'b1, 0, 0, 1'b1, ok, rac);
        exp = sb_q.pop_front();
        w0 = wr_count;
        bus.cmd_valid    = 1'b1;
        bus.cmd_row_addr = 16'h7777;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (bus.row_wr_valid !== 1'b1 || bus.row_wr_addr !== exp.addr || bus.row_wr_data !== exp.data ||
                bus.cmd_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold cycle %0d got valid=%b addr=%h data_match=%b cmd_ready=%b in_ready=%b exp 1 %h 1 0 0",
                         c, bus.row_wr_valid, bus.row_wr_addr, bus.row_wr_data === exp.data,
                         bus.cmd_ready, bus.in_ready, exp.addr);
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        vectors++;
        if (wr_count != w0) begin
            miscompares++;
            $display("[TB] FAIL bp_early_write got %0d writes exp 0", wr_count - w0);
        end
        row_handshake();
        vectors++;
        if (wr_count != w0 + 1 || bus.row_wr_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_release got writes=%0d valid=%b cmd_ready=%b exp 1 0 1",
                     wr_count - w0, bus.row_wr_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_missing_last();
        row_exp_t exp;
        bit ok, rac, blocked;
        int e0, bad;
        e0 = err_cycles;
        drive_row(16'h0056, NUM, 1'b0, 0, 0, 1'b1, ok, rac);
        vectors++;
        if (!ok || bus.row_wr_valid !== 1'b1 || err_len !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL nolast_commit got ok=%b valid=%b err_len=%b exp 1 1 1",
                     ok, bus.row_wr_valid, err_len);
        end
        blocked = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            if (bus.in_ready !== 1'b0) blocked = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (!blocked) begin
            miscompares++;
            $display("[TB] FAIL nolast_in_ready got high during commit exp 0");
        end
        vectors++;
        if (err_cycles - e0 != 1) begin
            miscompares++;
            $display("[TB] FAIL nolast_err_pulse got %0d high cycles exp 1", err_cycles - e0);
        end
        exp = sb_q.pop_front();
        bad = -1;
        for (int i = NUM - 1; i >= 0; i--)
            if (bus.row_wr_data[i*EW +: EW] !== exp.data[i*EW +: EW]) bad = i;
        vectors++;
        if (bad >= 0 || bus.row_wr_addr !== exp.addr) begin
            miscompares++;
            $display("[TB] FAIL nolast_row entry %0d addr %h exp addr %h", bad, bus.row_wr_addr, exp.addr);
        end
        row_handshake();
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL nolast_idle got in_ready=%b cmd_ready=%b exp 0 1", bus.in_ready, bus.cmd_ready);
        end
    endtask

    task automatic test_bubbles();
        row_exp_t exp;
        bit ok, rac;
        int e0, bad;
        e0 = err_cycles;
        drive_row(16'h0012, NUM, 1'b1, 0, 30, 1'b1, ok, rac);
        exp = sb_q.pop_front();
        bad = -1;
        for (int i = NUM - 1; i >= 0; i--)
            if (bus.row_wr_data[i*EW +: EW] !== exp.data[i*EW +: EW]) bad = i;
        vectors++;
        if (!ok || bus.row_wr_valid !== 1'b1 || bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL bubble_row got ok=%b valid=%b first_bad_entry=%0d exp 1 1 -1",
                     ok, bus.row_wr_valid, bad);
        end
        vectors++;
        if (err_cycles != e0) begin
            miscompares++;
            $display("[TB] FAIL bubble_err_len got %0d high cycles exp 0", err_cycles - e0);
        end
        row_handshake();
    endtask

    task automatic test_reset_mid_fill();
        row_exp_t exp;
        bit ok, rac;
        int v0, bad;
        drive_row(16'h0099, 100, 1'b0, 0, 0, 1'b0, ok, rac);
        v0 = valid_cycles;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b0 || bus.in_ready !== 1'b0 || bus.row_wr_valid !== 1'b0 ||
            busy !== 1'b0 || err_len !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_ctrl got cmd_ready=%b in_ready=%b valid=%b busy=%b err=%b exp all 0",
                     bus.cmd_ready, bus.in_ready, bus.row_wr_valid, busy, err_len);
        end
        vectors++;
        if (bus.row_wr_addr !== '0 || bus.row_wr_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_row got addr=%h data_nonzero=%b exp 0000 0",
                     bus.row_wr_addr, bus.row_wr_data != '0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (valid_cycles != v0 || bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_no_write got valid_cycles=%0d cmd_ready=%b exp 0 1",
                     valid_cycles - v0, bus.cmd_ready);
        end
        drive_row(16'h00AB, NUM, 1'b1, 0, 0, 1'b1, ok, rac);
        exp = sb_q.pop_front();
        bad = -1;
        for (int i = NUM - 1; i >= 0; i--)
            if (bus.row_wr_data[i*EW +: EW] !== exp.data[i*EW +: EW]) bad = i;
        vectors++;
        if (!ok || bus.row_wr_valid !== 1'b1 || bus.row_wr_addr !== exp.addr || bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_row got ok=%b valid=%b addr=%h first_bad_entry=%0d exp 1 1 %h -1",
                     ok, bus.row_wr_valid, bus.row_wr_addr, bad, exp.addr);
        end
        row_handshake();
    endtask

    task automatic test_write_count();
        vectors++;
        if (wr_count != 7 || sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL write_count got %0d writes, %0d queued exp 7 0", wr_count, sb_q.size());
        end
    endtask

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_row_addr = '0;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_last      = 1'b0;
        bus.row_wr_ready = 1'b0;
        test_reset();
        test_full_row();
        test_short_row();
        test_backpressure();
        test_missing_last();
        test_bubbles();
        test_reset_mid_fill();
        test_write_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got no completion exp finish within 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/clod_pim_lut_row_writer.md
Name: clod_pim_lut_row_writer

Overview:
- Write-side counterpart of the PIM LUT row read path: programs one LUT row that the row-buffer byte-select mux later reads.
- Accepts a row command, then a byte stream of LUT entries.
- Assembles the entries into a full row image.
- Issues one wide row write to the subarray write port, with a valid/ready handshake on every interface.

Parameters:
- num_row_elements, 256, entries per row; must be a power of two.
- element_width, 8, bits per entry.
- row_addr_width, 16, width of the subarray row address.
- idx_width, $clog2(num_row_elements), derived; width of the entry index (8 at default).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  row-program command valid.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_row_addr  in  row_addr_width  target row.
- in_valid  in  1  LUT entry valid.
- in_ready  out  1  entry accepted when valid&&ready.
- in_data  in  element_width  LUT entry value.
- in_last  in  1  marks final entry of the row.
- row_wr_valid  out  1  row image ready to write.
- row_wr_ready  in  1  subarray accepts the row.
- row_wr_addr  out  row_addr_width  latched cmd_row_addr.
- row_wr_data  out  num_row_elements*element_width  entry i at bits [i*element_width +: element_width].
- busy  out  1  high in FILL or COMMIT.
- err_len  out  1  one-cycle pulse on row length error.

Behaviour:
- Reset (synchronous): state=IDLE, idx=0, buffer all zero, row_wr_addr=0, row_wr_valid=0, in_ready=0, err_len=0, busy=0, cmd_ready=0 during reset.
- Reset mid-FILL or mid-COMMIT abandons the row; no row write is issued.
- IDLE:
  - cmd_ready=1, in_ready=0.
  - On cmd handshake: latch cmd_row_addr, clear every buffer entry to 0, idx=0, go to FILL.
- FILL:
  - in_ready=1, cmd_ready=0.
  - Each accepted entry: buffer[idx]<=in_data, idx<=idx+1. Entries are written strictly in arrival order. Bubbles (in_valid=0) are allowed.
  - Accept with idx==num_row_elements-1 and in_last=1: go to COMMIT, err_len=0.
  - Accept with idx==num_row_elements-1 and in_last=0: go to COMMIT, err_len pulses the next cycle. The row is treated as complete.
  - Accept with in_last=1 and idx<num_row_elements-1 (short row): go to COMMIT, err_len pulses the next cycle. Unwritten entries remain 0.
- COMMIT:
  - row_wr_valid=1; row_wr_addr and row_wr_data are held stable until the handshake.
  - cmd_ready=0, in_ready=0.
  - On row_wr_valid&&row_wr_ready: go to IDLE; row_wr_valid=0 the next cycle.
- Latency:
  - Cmd accepted at cycle t: the first entry can be accepted at t+1.
  - Final entry accepted at cycle u: row_wr_valid=1 at u+1.
  - Throughput is one entry per cycle; a back-to-back command is accepted at the earliest one cycle after the row handshake (IDLE cycle).
- idx never wraps: the transition to COMMIT occurs at num_row_elements-1.
- No combinational path from any input to any ready or valid output.
- Index mapping: entry i is the byte selected by sel_op==i on the read mux.

Decomposition:
- Package clod_pim_pkg holds:
  - CLOD_ELEMENT_WIDTH=8
  - CLOD_NUM_ROW_ELEMENTS=256
  - CLOD_ROW_ADDR_WIDTH=16
  - CLOD_IDX_WIDTH=8
  - typedef of writer state enum {IDLE, FILL, COMMIT}
- One sub-module: clod_pim_row_assembly_buffer.
  - Entry storage with indexed single-entry write and synchronous clear-all.
  - Flat row output.
- The FSM, counter and handshakes stay in the top module.

Test Plan:
1. Full row:
   - Stimulus: cmd_row_addr=0x0012; 256 entries with in_data=k^0xA5, in_last on k=255.
   - Required: row_wr_valid one cycle after the last accept; row_wr_addr=0x0012; entry k=k^0xA5; err_len never high.
2. Backpressure:
   - Stimulus: as scenario 1, with row_wr_ready low for 10 cycles.
   - Required: row_wr_valid, addr and data held constant; cmd_ready=0 and in_ready=0 throughout; handshake on the 11th cycle, then IDLE.
3. Short row after a full row:
   - Stimulus: scenario 1, then cmd addr 0x0034 with entries 0x11,0x22,0x33,0x44, in_last on 0x44.
   - Required: entries 0..3 = those values, entries 4..255 = 0x00 (no stale 0xA5 pattern); err_len single pulse.
4. Missing last:
   - Stimulus: 256 entries with in_last never set.
   - Required: commit after the 256th accept; err_len single pulse; in_ready=0 afterwards until the next command.
5. Stream bubbles:
   - Stimulus: in_valid randomly deasserted, 30% duty gaps, with scenario 1 data.
   - Required: row image identical to scenario 1; idx advances only on handshake.
6. Reset mid-FILL:
   - Stimulus: rst asserted for 1 cycle after 100 entries.
   - Required: all outputs at reset values; no row_wr_valid ever; a following full-row command produces a correct row.
